// File: rtl/ret_share_arb.sv
// Round-robin (burst-locked) arbiter sharing a 3-stage XOR/AND reduction pipe among requesters.
// Define RET_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module ret_share_arb #(
   parameter int unsigned SIZE    = 8,
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned BURST   = 2,
   parameter int unsigned IDW     = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [NUM_REQ*SIZE-1:0] op_a,
   input  logic [NUM_REQ*SIZE-1:0] op_b,
   output logic [NUM_REQ-1:0]      gnt,
   output logic                    res_valid,
   output logic                    res_data,
   output logic [IDW-1:0]          res_id,
   input  logic                    res_ready,
   output logic                    busy
);

   logic            adv;
   logic            acc;
   logic            found;
   logic [IDW-1:0]  gnt_idx;

   logic            s1_v_q;
   logic [SIZE-1:0] s1_a_q;
   logic [SIZE-1:0] s1_b_q;
   logic [IDW-1:0]  s1_id_q;
   logic            s2_v_q;
   logic            s2_bit_q;
   logic [IDW-1:0]  s2_id_q;
   logic            res_valid_q;
   logic            res_data_q;
   logic [IDW-1:0]  res_id_q;
   logic            red_bit;

   // Whole pipe moves together; only a refused result stalls it.
   assign adv = !res_valid_q || res_ready;

`ifdef RET_FIXED_PRIO_EN
   always_comb begin
      found   = 1'b0;
      gnt_idx = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!found && req[i]) begin
            found   = 1'b1;
            gnt_idx = IDW'(i);
         end
      end
   end
`else
   localparam int unsigned CW = 4;

   logic [IDW-1:0] ptr_q, ptr_d, ptr_nxt, start;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           own_q, own_d;
   logic           keep;
   int unsigned    j;

   // While own_q is set, ptr_q names the current owner.
   always_comb begin
      ptr_nxt = (ptr_q == IDW'(NUM_REQ - 1)) ? '0 : ptr_q + 1'b1;
      keep    = own_q && req[ptr_q] && (cnt_q < CW'(BURST));
      start   = own_q ? ptr_nxt : ptr_q;
      found   = keep;
      gnt_idx = ptr_q;
      j       = 0;
      if (!keep) begin
         for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j = (32'(start) + k) % NUM_REQ;
            if (!found && req[j]) begin
               found   = 1'b1;
               gnt_idx = IDW'(j);
            end
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      own_d = own_q;
      if (adv && found) begin
         ptr_d = gnt_idx;
         own_d = 1'b1;
         cnt_d = keep ? cnt_q + 1'b1 : CW'(1);
      end else if (own_q && !keep) begin
         ptr_d = ptr_nxt;
         own_d = 1'b0;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
         cnt_q <= '0;
         own_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
         own_q <= own_d;
      end
   end
`endif

   assign acc = adv && found;

   always_comb begin
      gnt = '0;
      if (acc) begin
         gnt[gnt_idx] = 1'b1;
      end
   end

   assign red_bit = (&(s1_a_q ^ s1_b_q)) | (^(s1_a_q & s1_b_q));

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v_q      <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_id_q     <= '0;
         s2_v_q      <= 1'b0;
         s2_bit_q    <= 1'b0;
         s2_id_q     <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= 1'b0;
         res_id_q    <= '0;
      end else if (adv) begin
         s1_v_q      <= acc;
         s1_a_q      <= op_a[int'(gnt_idx)*SIZE +: SIZE];
         s1_b_q      <= op_b[int'(gnt_idx)*SIZE +: SIZE];
         s1_id_q     <= gnt_idx;
         s2_v_q      <= s1_v_q;
         s2_bit_q    <= red_bit;
         s2_id_q     <= s1_id_q;
         res_valid_q <= s2_v_q;
         if (s2_v_q) begin
            res_data_q <= s2_bit_q;
            res_id_q   <= s2_id_q;
         end
      end
   end

   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_id    = res_id_q;
   assign busy      = s1_v_q || s2_v_q || res_valid_q;

endmodule

// File: tb/tb_ret_share_arb.sv
// Self-checking bench for ret_share_arb: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue/arithmetic reference model.
module tb_ret_share_arb;

   localparam int SIZE  = 8;
   localparam int N     = 4;
   localparam int BURST = 2;
   localparam int IDW   = 2;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [N-1:0]        req = '0;
   logic [N*SIZE-1:0]   op_a = '0;
   logic [N*SIZE-1:0]   op_b = '0;
   logic                res_ready = 1'b1;
   logic [N-1:0]        gnt;
   logic                res_valid;
   logic                res_data;
   logic [IDW-1:0]      res_id;
   logic                busy;

   int n_chk = 0;
   int n_err = 0;

   ret_share_arb #(
      .SIZE    (SIZE),
      .NUM_REQ (N),
      .BURST   (BURST),
      .IDW     (IDW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .op_a      (op_a),
      .op_b      (op_b),
      .gnt       (gnt),
      .res_valid (res_valid),
      .res_data  (res_data),
      .res_id    (res_id),
      .res_ready (res_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   function automatic bit ref_red(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
      return ((a ^ b) == {SIZE{1'b1}}) || (($countones(a & b) % 2) == 1);
   endfunction

   // Reference model: 3 in-flight slots (slot 2 is what the output shows) and arbiter bookkeeping.
   bit           armed = 1'b0;
   bit           mv [3];
   bit           md [3];
   int           mid [3];
   int           owner = -1;
   int           count = 0;
   int           ptr = 0;
   bit           e_adv;
   bit           keep;
   int           ch;
   int           start;
   logic [N-1:0] e_gnt;

   always @(negedge clk) begin
      if (armed) begin
         e_adv = !(mv[2] && !res_ready);
         keep  = (owner >= 0) ? (req[owner] && count < BURST) : 1'b0;
         ch    = -1;
         if (keep) begin
            ch = owner;
         end else begin
            start = (owner >= 0) ? (owner + 1) % N : ptr;
            for (int k = 0; k < N; k++) begin
               if (ch < 0 && req[(start + k) % N]) ch = (start + k) % N;
            end
         end
         e_gnt = '0;
         if (e_adv && ch >= 0) e_gnt[ch] = 1'b1;
         chk("model_gnt", 32'(gnt), 32'(e_gnt));
         chk("model_res_valid", 32'(res_valid), 32'(mv[2]));
         if (mv[2]) begin
            chk("model_res_data", 32'(res_data), 32'(md[2]));
            chk("model_res_id", 32'(res_id), 32'(mid[2]));
         end
         chk("model_busy", 32'(busy), 32'(mv[0] || mv[1] || mv[2]));
         if (!rst) begin
            if (e_adv) begin
               mv[2] = mv[1]; md[2] = md[1]; mid[2] = mid[1];
               mv[1] = mv[0]; md[1] = md[0]; mid[1] = mid[0];
               mv[0] = (ch >= 0);
               if (ch >= 0) begin
                  md[0]  = ref_red(op_a[ch*SIZE +: SIZE], op_b[ch*SIZE +: SIZE]);
                  mid[0] = ch;
               end
            end
            if (e_adv && ch >= 0) begin
               count = (ch == owner && keep) ? count + 1 : 1;
               owner = ch;
            end else if (owner >= 0 && !keep) begin
               ptr   = (owner + 1) % N;
               owner = -1;
               count = 0;
            end
         end
      end
      if (rst) begin
         armed = 1'b1;
         mv    = '{1'b0, 1'b0, 1'b0};
         owner = -1;
         count = 0;
         ptr   = 0;
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   task automatic rand_ops();
      for (int i = 0; i < N; i++) begin
         op_a[i*SIZE +: SIZE] = SIZE'($urandom);
         op_b[i*SIZE +: SIZE] = SIZE'($urandom);
      end
   endtask

   task automatic beat_lat(input logic [7:0] a, input logic [7:0] b, input logic exp_bit,
                           input string nm);
      op_a = '0;
      op_b = '0;
      op_a[SIZE-1:0] = a;
      op_b[SIZE-1:0] = b;
      req = 4'b0001;
      smp(); chk({nm, "_gnt_T"}, 32'(gnt), 32'h1);
      cyc(); req = '0;
      smp(); chk({nm, "_valid_T1"}, 32'(res_valid), 0);
      cyc();
      smp(); chk({nm, "_valid_T2"}, 32'(res_valid), 0);
      cyc();
      smp(); chk({nm, "_valid_T3"}, 32'(res_valid), 1);
      chk({nm, "_data_T3"}, 32'(res_data), 32'(exp_bit));
      chk({nm, "_id_T3"}, 32'(res_id), 0);
      cyc();
      smp(); chk({nm, "_busy_T4"}, 32'(busy), 0);
      chk({nm, "_valid_T4"}, 32'(res_valid), 0);
      cyc();
   endtask

   int order [12] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 1, 1};
   int stall_ids [3] = '{1, 1, 0};
   int ids [$];

   initial begin : stim
      do_reset();
      res_ready = 1'b1;
      smp();
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_res_valid", 32'(res_valid), 0);
      chk("rst_res_data", 32'(res_data), 0);
      chk("rst_res_id", 32'(res_id), 0);
      chk("rst_busy", 32'(busy), 0);
      cyc();

      beat_lat(8'hFF, 8'h00, 1'b1, "lat_ff_00");
      beat_lat(8'h0F, 8'h0F, 1'b0, "dp_0f_0f");
      beat_lat(8'h01, 8'h01, 1'b1, "dp_01_01");

      // Round-robin with burst locking, all requesters active.
      do_reset();
      rand_ops();
      req = '1;
      for (int k = 0; k < 12; k++) begin
         smp();
         if (k < 9) chk("rr_gnt", 32'(gnt), 32'(1) << order[k]);
         if (k >= 3) begin
            chk("rr_res_valid", 32'(res_valid), 1);
            chk("rr_res_id", 32'(res_id), 32'(order[k-3]));
         end
         cyc();
      end
      req = '0;

      // Stall with a full pipe, then drain.
      do_reset();
      req = 4'b0011;
      repeat (5) begin smp(); cyc(); end
      res_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         smp();
         chk("stall_gnt", 32'(gnt), 0);
         chk("stall_res_valid", 32'(res_valid), 1);
         chk("stall_res_id", 32'(res_id), 1);
         chk("stall_busy", 32'(busy), 1);
         cyc();
      end
      res_ready = 1'b1;
      req = '0;
      ids.delete();
      for (int k = 0; k < 6; k++) begin
         smp();
         if (res_valid) ids.push_back(int'(res_id));
         cyc();
      end
      chk("stall_drain_count", 32'(ids.size()), 3);
      if (ids.size() == 3) begin
         for (int k = 0; k < 3; k++) chk("stall_drain_id", 32'(ids[k]), 32'(stall_ids[k]));
      end

      // Reset with beats in flight.
      do_reset();
      req = '1;
      repeat (4) begin smp(); cyc(); end
      rst = 1'b1;
      smp();
      cyc();
      rst = 1'b0;
      smp();
      chk("midrst_gnt_ptr0", 32'(gnt), 32'h1);
      chk("midrst_res_valid", 32'(res_valid), 0);
      chk("midrst_busy", 32'(busy), 0);
      cyc();
      req = '0;
      smp(); chk("midrst_no_stale1", 32'(res_valid), 0);
      cyc();
      smp(); chk("midrst_no_stale2", 32'(res_valid), 0);
      cyc();
      smp(); chk("midrst_new_valid", 32'(res_valid), 1);
      chk("midrst_new_id", 32'(res_id), 0);
      cyc();

      // Randomized traffic, checked by the model every cycle.
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 3) == 0) req = N'($urandom);
         rand_ops();
         res_ready = ($urandom_range(0, 9) < 7);
         rst = ($urandom_range(0, 299) == 0);
         smp();
         cyc();
      end
      rst = 1'b0;
      req = '0;
      res_ready = 1'b1;
      repeat (6) begin smp(); cyc(); end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
